// File: rtl/lattice_pkg.sv
// -----------------------------------------------------------------------------
// lattice_pkg
// Shared types and constants for the lattice result path.
//   collector_state_t : collector FSM states
//   result_entry_t    : one result as it travels the chain {core, value},
//                       laid out for the default configuration (10 cores,
//                       32-bit values)
//   STALL_EXTRA       : stall headroom beyond one slot per in-flight core
// -----------------------------------------------------------------------------
package lattice_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } collector_state_t;

    // Two extra slots cover the registered stall flag and the feeder's
    // reaction cycle on top of the results already inside the chain.
    localparam int STALL_EXTRA = 2;

    localparam int DEF_CORE_W = 4;
    localparam int DEF_DATA_W = 32;

    typedef struct packed {
        logic [DEF_CORE_W-1:0] core;
        logic [DEF_DATA_W-1:0] value;
    } result_entry_t;

endpackage

// File: rtl/lattice_result_fifo.sv
// -----------------------------------------------------------------------------
// lattice_result_fifo
// Synchronous first-word-fall-through FIFO over a registered array.
//   clk, rst   : clock, asynchronous active-low reset (pointers only)
//   push/wdata : write request and data
//   pop        : read request; ignored while empty
//   rdata      : head entry, valid whenever empty is low
//   full/empty : status
//   level      : number of stored entries
// A push while full is accepted only when a pop frees the slot on the same
// edge; otherwise it is dropped.
// -----------------------------------------------------------------------------
module lattice_result_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int ADDR_W = $clog2(DEPTH);

    // One extra pointer bit: equal low bits with differing MSBs means full.
    logic [ADDR_W:0]   wptr_q, rptr_q;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic              do_push, do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                     (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);
    assign level   = wptr_q - rptr_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rptr_q[ADDR_W-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone
    // define which entries are live, and a resettable array costs a flop
    // reset per bit for no functional gain.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[ADDR_W-1:0]] <= wdata;
    end

endmodule

// File: rtl/lattice_result_collector.sv
// -----------------------------------------------------------------------------
// lattice_result_collector
// Terminus of the lattice core chain. Buffers per-core results in a FIFO and
// hands them to the host over valid/ready, tracking a per-batch result count.
//   clk, rst              : clock, asynchronous active-low reset
//   batch_start/expected  : arm a batch with its expected result count
//   res_valid/core/value  : result stream from the chain (no back-pressure)
//   out_valid/ready/core/value/last : host-side handshake, last marks the
//                           final result of the batch
//   stall_o               : registered request for the feeder to stop
//   batch_done            : one-cycle pulse after the final host pop
//   overflow              : sticky, a result was dropped or arrived illegally
//   busy                  : a batch is in progress
// -----------------------------------------------------------------------------
module lattice_result_collector
    import lattice_pkg::*;
#(
    parameter int NUM_CORES  = 10,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int COUNTBITS  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          batch_start,
    input  logic [COUNTBITS-1:0]          batch_expected,
    input  logic                          res_valid,
    input  logic [$clog2(NUM_CORES)-1:0]  res_core,
    input  logic [DATA_WIDTH-1:0]         res_value,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(NUM_CORES)-1:0]  out_core,
    output logic [DATA_WIDTH-1:0]         out_value,
    output logic                          out_last,
    output logic                          stall_o,
    output logic                          batch_done,
    output logic                          overflow,
    output logic                          busy
);

    localparam int CORE_W       = $clog2(NUM_CORES);
    localparam int ADDR_W       = $clog2(DEPTH);
    localparam int ENTRY_W      = CORE_W + DATA_WIDTH;
    localparam int STALL_MARGIN = NUM_CORES + STALL_EXTRA;
    localparam logic [ADDR_W:0] STALL_LEVEL = (ADDR_W+1)'(DEPTH - STALL_MARGIN);

    collector_state_t      state_q, state_d;
    logic [COUNTBITS-1:0]  expected_q, expected_d;
    logic [COUNTBITS-1:0]  recv_cnt_q, recv_cnt_d;
    logic [COUNTBITS-1:0]  sent_cnt_q, sent_cnt_d;
    logic                  overflow_q, overflow_d;
    logic                  batch_done_q, batch_done_d;
    logic                  stall_q, stall_d;

    logic                  push, pop, push_acc;
    logic                  fifo_full, fifo_empty;
    logic [ENTRY_W-1:0]    fifo_rdata;
    logic [ADDR_W:0]       fifo_level, level_next;

    // Results are only buffered while collecting; anything else is an error.
    assign push       = res_valid && (state_q == COLLECT);
    assign pop        = out_valid && out_ready;
    assign push_acc   = push && (!fifo_full || pop);
    assign level_next = fifo_level + (ADDR_W+1)'(push_acc) - (ADDR_W+1)'(pop);

    lattice_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({res_core, res_value}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // NOTE: every next-state variable takes its current value first, so no
    // path through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        expected_d   = expected_q;
        recv_cnt_d   = recv_cnt_q;
        sent_cnt_d   = sent_cnt_q;
        overflow_d   = overflow_q;
        batch_done_d = 1'b0;
        stall_d      = (level_next >= STALL_LEVEL);

        if (pop) sent_cnt_d = sent_cnt_q + COUNTBITS'(1);

        case (state_q)
            IDLE: begin
                if (res_valid) overflow_d = 1'b1;
                if (batch_start) begin
                    expected_d = batch_expected;
                    recv_cnt_d = '0;
                    sent_cnt_d = '0;
                    if (batch_expected == '0) batch_done_d = 1'b1;
                    else                      state_d      = COLLECT;
                end
            end
            COLLECT: begin
                if (res_valid) begin
                    // A dropped result still counts so the batch terminates.
                    recv_cnt_d = recv_cnt_q + COUNTBITS'(1);
                    if (!push_acc) overflow_d = 1'b1;
                    if (recv_cnt_d == expected_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (res_valid) overflow_d = 1'b1;
                if (pop && sent_cnt_d == expected_q) begin
                    state_d      = IDLE;
                    batch_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            expected_q   <= '0;
            recv_cnt_q   <= '0;
            sent_cnt_q   <= '0;
            overflow_q   <= 1'b0;
            batch_done_q <= 1'b0;
            stall_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            expected_q   <= expected_d;
            recv_cnt_q   <= recv_cnt_d;
            sent_cnt_q   <= sent_cnt_d;
            overflow_q   <= overflow_d;
            batch_done_q <= batch_done_d;
            stall_q      <= stall_d;
        end
    end

    // Head data is masked while empty so outputs read zero after reset even
    // though the storage array itself is never cleared.
    assign out_valid  = !fifo_empty;
    assign out_core   = out_valid ? fifo_rdata[ENTRY_W-1:DATA_WIDTH] : '0;
    assign out_value  = out_valid ? fifo_rdata[DATA_WIDTH-1:0]       : '0;
    assign out_last   = out_valid && (sent_cnt_q == expected_q - COUNTBITS'(1));
    assign stall_o    = stall_q;
    assign batch_done = batch_done_q;
    assign overflow   = overflow_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: doc/lattice_result_collector.md
# lattice_result_collector

Downstream terminus of the lattice core chain: accepts one result per cycle from the last `lattice_block` result stage, buffers results in a FIFO, and delivers them to the host-side link over a valid/ready handshake. It counts results against a per-batch expected total, raises `batch_done` when the batch is fully drained, and drives `stall_o` back to the input feeder, since the core chain itself cannot be back-pressured.

## Interface
Parameters:
- `NUM_CORES`, 10, cores in the chain; sets `STALL_MARGIN` and the width of `core_idx`.
- `DATA_WIDTH`, 32, result value width.
- `DEPTH`, 32, FIFO entries; power of two; must be greater than `NUM_CORES`.
- `COUNTBITS`, 16, width of the batch result counters.

Ports (reset is asynchronous and active-low; clock `clk`, reset `rst`):
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous active-low reset.
- `batch_start`  in  1  pulse; arms a new batch.
- `batch_expected`  in  COUNTBITS  results expected; sampled with `batch_start`.
- `res_valid`  in  1  result present from the chain.
- `res_core`  in  $clog2(NUM_CORES)  originating core index.
- `res_value`  in  DATA_WIDTH  result value.
- `out_valid`  out  1  output entry valid.
- `out_ready`  in  1  host accepts.
- `out_core`  out  $clog2(NUM_CORES)  core index of the head entry.
- `out_value`  out  DATA_WIDTH  value of the head entry.
- `out_last`  out  1  head entry is the final result of the batch.
- `stall_o`  out  1  feeder must stop issuing work.
- `batch_done`  out  1  one-cycle pulse after the last result is accepted by the host.
- `overflow`  out  1  sticky; a result arrived while the FIFO was full.
- `busy`  out  1  state is not IDLE.

## Operation
- States:
  - IDLE: `batch_start` loads `expected` and clears `recv_cnt` and `sent_cnt`, then goes to COLLECT. If `batch_expected` is 0, it pulses `batch_done` the next cycle and stays in IDLE.
  - COLLECT: every `res_valid` is pushed and `recv_cnt` increments. Go to DRAIN when `recv_cnt` reaches `expected` (including the push on that cycle).
  - DRAIN: `res_valid` is ignored and counted as an error; it sets `overflow`. Return to IDLE when `sent_cnt` reaches `expected`, and pulse `batch_done` on that transition.
- `res_valid` in IDLE is dropped and sets `overflow`.
- `batch_start` outside IDLE is ignored.
- FIFO:
  - Read and write pointers are $clog2(DEPTH)+1 bits, so full and empty are distinguishable by the MSB.
  - A push while full is dropped: `overflow` is set and `recv_cnt` still increments, so the batch terminates.
  - A simultaneous push and pop while full succeeds; the pop frees the slot in the same cycle.
- `out_last` = (`sent_cnt` == `expected` − 1) and `out_valid`.
- `stall_o` = fill level ≥ DEPTH − `STALL_MARGIN`, where `STALL_MARGIN` = `NUM_CORES` + 2. This covers results already in flight through the chain.
- Counters wrap modulo 2^COUNTBITS. `expected` is at most 2^COUNTBITS − 1.
- `overflow` clears only on reset.

## Timing
- Reset values:
  - Outputs: `out_valid`=0, `out_core`=0, `out_value`=0, `out_last`=0, `stall_o`=0, `batch_done`=0, `overflow`=0, `busy`=0.
  - Internal: state=IDLE, pointers=0.
- Latency: a push at edge N makes `out_valid` high after edge N (first-word fall-through from a registered array). Minimum latency is 1 cycle.
- Handshake: the pop happens on a cycle where `out_valid` and `out_ready` are both high. `out_valid` never drops without a pop. `out_core` and `out_value` are stable while stalled.
- `stall_o` is registered and reflects the fill level after the current edge.
- `batch_done` is asserted the cycle after the final pop, for exactly 1 cycle.
- Reset asserted mid-batch: all state clears asynchronously and FIFO contents are discarded.
- Throughput: 1 push and 1 pop per cycle.

## Structure
- Shared package `lattice_pkg`:
  - `collector_state_t` enum (IDLE, COLLECT, DRAIN).
  - `result_entry_t` packed struct {core, value}.
  - `STALL_EXTRA` constant = 2.
- Sub-module `lattice_result_fifo`: parameterised synchronous FIFO with `push`, `pop`, `full`, `empty` and `level`. The top level holds the FSM, counters and flags.

## Test plan
- Basic batch, DEPTH=32, NUM_CORES=10, `out_ready`=1:
  - Stimulus: `batch_expected`=5; results 0xA0..0xA4 arrive on consecutive cycles.
  - Required: outputs appear in order, one cycle later each; `out_last` is high on 0xA4; `batch_done` pulses once on the following cycle; `overflow`=0.
- Back-pressure:
  - Stimulus: `out_ready`=0; 20 results pushed.
  - Required: `stall_o` rises when level reaches 20 (32−12); `out_value` is held stable.
  - Then release `out_ready`: all 20 drain in order; `stall_o` falls when level drops to 19.
- Overflow:
  - Stimulus: `out_ready`=0; 33 results pushed in a batch of 33.
  - Required: the 33rd is dropped, `overflow`=1 (sticky), state goes to DRAIN.
  - Draining 32 entries does not reach `sent_cnt`=33, so the FSM stays in DRAIN until reset. Also check that reset clears it.
- Full with simultaneous push/pop:
  - Stimulus: FIFO holds 32 entries; assert `res_valid` with `out_ready`=1.
  - Required: no overflow; level stays at 32.
- Zero and illegal events:
  - `batch_expected`=0 → `batch_done` pulses after 1 cycle, `busy` stays 0.
  - `res_valid` in IDLE → `overflow`=1.
  - `batch_start` during COLLECT → ignored; `expected` unchanged.
- Reset mid-batch:
  - Stimulus: after 3 of 8 results, pulse `rst`=0 asynchronously.
  - Required: all outputs go to 0 immediately; a new batch of 2 then completes normally.
